// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: owns the HD44780 bus, runs the power-on init, then arbitrates two write ports round-robin.
// Build option: define LCD_SCHED_INIT_SEQ_EN to compile in the PWRUP/INIT sequence and the init ROM.
module lcd_bus_scheduler #(
    parameter int unsigned CLK_MHZ = 50,
    parameter int unsigned T_SU    = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_H     = 2,
    parameter int unsigned T_SHORT = 2650,
    parameter int unsigned T_LONG  = 152000,
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_INIT1 = 205000,
    parameter int unsigned T_INIT2 = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic       a_rs,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_rs,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       init_done,
    output logic       busy,
    output logic       LCD_RS,
    output logic       LCD_EN,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);
    function automatic int unsigned max2(input int unsigned x, input int unsigned y);
        max2 = (x > y) ? x : y;
    endfunction

    localparam int unsigned MAX_BUS  = max2(max2(T_SU, T_EN), max2(T_H, max2(T_SHORT, T_LONG)));
    localparam int unsigned MAX_INIT = max2(T_PWRUP, max2(T_INIT1, T_INIT2));
    localparam int unsigned MAX_T    = max2(MAX_BUS, MAX_INIT);
    localparam int unsigned CW       = $clog2(MAX_T + 1);

    if (CLK_MHZ == 0 || T_SU == 0 || T_EN == 0 || T_H == 0 || T_SHORT == 0 || T_LONG == 0 ||
        T_PWRUP == 0 || T_INIT1 == 0 || T_INIT2 == 0) begin : g_cfg_check
        $error("lcd_bus_scheduler: all timing parameters must be nonzero");
    end

    typedef enum logic [2:0] {PWRUP, INIT, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [CW-1:0]   wait_len, wait_next;
    logic            last_b, last_next;
    logic            rs_next, en_next, busy_next, done_next;
    logic [7:0]      data_next;
    logic            idle_ok, accept, sel_rs, exec_long;
    logic [7:0]      sel_data;

    assign LCD_RW = 1'b0;

    // Round-robin grant: with both ports valid, the one not granted last wins.
    assign idle_ok   = (state == IDLE) && init_done;
    assign a_ready   = idle_ok && a_valid && (!b_valid || last_b);
    assign b_ready   = idle_ok && b_valid && (!a_valid || !last_b);
    assign accept    = a_ready || b_ready;
    assign sel_rs    = a_ready ? a_rs : b_rs;
    assign sel_data  = a_ready ? a_data : b_data;
    assign exec_long = !sel_rs && (sel_data[7:2] == 6'd0);

`ifdef LCD_SCHED_INIT_SEQ_EN
    logic [2:0] idx, idx_next;

    function automatic logic [7:0] rom_byte(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: rom_byte = 8'h30;
            3'd3:             rom_byte = 8'h38;
            3'd4:             rom_byte = 8'h08;
            3'd5:             rom_byte = 8'h01;
            3'd6:             rom_byte = 8'h06;
            default:          rom_byte = 8'h0C;
        endcase
    endfunction

    function automatic logic [CW-1:0] rom_wait(input logic [2:0] i);
        case (i)
            3'd0:    rom_wait = CW'(T_INIT1);
            3'd1:    rom_wait = CW'(T_INIT2);
            3'd5:    rom_wait = CW'(T_LONG);
            default: rom_wait = CW'(T_SHORT);
        endcase
    endfunction
`endif

    // State register plus registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef LCD_SCHED_INIT_SEQ_EN
            state <= PWRUP;
            cnt   <= CW'(T_PWRUP - 1);
            busy  <= 1'b1;
            idx   <= 3'd0;
`else
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
`endif
            wait_len  <= '0;
            last_b    <= 1'b1;
            init_done <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_EN    <= 1'b0;
            LCD_DATA  <= 8'h00;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            busy      <= busy_next;
`ifdef LCD_SCHED_INIT_SEQ_EN
            idx       <= idx_next;
`endif
            wait_len  <= wait_next;
            last_b    <= last_next;
            init_done <= done_next;
            LCD_RS    <= rs_next;
            LCD_EN    <= en_next;
            LCD_DATA  <= data_next;
        end
    end

    // Next state; each state lasts exactly its count, counter reloads on entry.
    always_comb begin
        state_next = state;
        cnt_next   = (cnt != '0) ? cnt - CW'(1) : cnt;
        case (state)
`ifdef LCD_SCHED_INIT_SEQ_EN
            PWRUP: if (cnt == '0) begin
                state_next = INIT;
                cnt_next   = '0;
            end
            INIT: begin
                state_next = SETUP;
                cnt_next   = CW'(T_SU - 1);
            end
`endif
            SETUP: if (cnt == '0) begin
                state_next = PULSE;
                cnt_next   = CW'(T_EN - 1);
            end
            PULSE: if (cnt == '0) begin
                state_next = HOLD;
                cnt_next   = CW'(T_H - 1);
            end
            HOLD: if (cnt == '0) begin
                state_next = WAIT;
                cnt_next   = wait_len - CW'(1);
            end
            WAIT: if (cnt == '0) begin
                cnt_next   = '0;
`ifdef LCD_SCHED_INIT_SEQ_EN
                state_next = (init_done || idx == 3'd7) ? IDLE : INIT;
`else
                state_next = IDLE;
`endif
            end
            IDLE: if (accept) begin
                state_next = SETUP;
                cnt_next   = CW'(T_SU - 1);
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        rs_next   = LCD_RS;
        data_next = LCD_DATA;
        wait_next = wait_len;
        last_next = last_b;
        done_next = init_done;
        en_next   = (state_next == PULSE);
        busy_next = (state_next != IDLE);
`ifdef LCD_SCHED_INIT_SEQ_EN
        idx_next  = idx;
        if (state == INIT) begin
            rs_next   = 1'b0;
            data_next = rom_byte(idx);
            wait_next = rom_wait(idx);
        end
        if (state == WAIT && cnt == '0 && !init_done) begin
            if (idx == 3'd7) done_next = 1'b1;
            else             idx_next  = idx + 3'd1;
        end
`else
        done_next = 1'b1;
`endif
        if (accept) begin
            rs_next   = sel_rs;
            data_next = sel_data;
            wait_next = exec_long ? CW'(T_LONG) : CW'(T_SHORT);
            last_next = b_ready;
        end
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed self-checking bench for lcd_bus_scheduler with shortened timing parameters.
module tb_lcd_bus_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_rs, b_valid, b_rs;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, init_done, busy;
    logic       LCD_RS, LCD_EN, LCD_RW;
    logic [7:0] LCD_DATA;

    int compared   = 0;
    int mismatched = 0;

    lcd_bus_scheduler #(
        .CLK_MHZ(50), .T_SU(1), .T_EN(2), .T_H(1), .T_SHORT(10), .T_LONG(40),
        .T_PWRUP(20), .T_INIT1(15), .T_INIT2(12)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rs(a_rs), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rs(b_rs), .b_data(b_data), .b_ready(b_ready),
        .init_done(init_done), .busy(busy),
        .LCD_RS(LCD_RS), .LCD_EN(LCD_EN), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            step(1);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic watch_no_en(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            step(1);
            if (LCD_EN) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    // One request from a single port; accept-to-IDLE must take 'cycles'.
    task automatic xfer(input logic port_b, input logic rs, input logic [7:0] d, input int cycles);
        if (port_b) begin b_valid = 1'b1; b_rs = rs; b_data = d; end
        else        begin a_valid = 1'b1; a_rs = rs; a_data = d; end
        #1;
        check("xfer_ready", port_b ? b_ready : a_ready, 1);
        check("xfer_other_ready", port_b ? a_ready : b_ready, 0);
        step(1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("xfer_rs", LCD_RS, rs);
        check("xfer_data", LCD_DATA, d);
        step(1);
        check("xfer_en", LCD_EN, 1);
        step(cycles - 2);
        check("xfer_busy_before", busy, 1);
        step(1);
        check("xfer_busy_after", busy, 0);
    endtask

`ifdef LCD_SCHED_INIT_SEQ_EN
    // Release to first EN rise is 21 cycles, then the full ROM replays.
    task automatic check_init(input logic full);
        logic [7:0] rom [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        watch_no_en("pwrup_no_en", 21);
        step(1);
        check("first_en_rise", LCD_EN, 1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                int n = 0;
                while (!LCD_EN && n < 400) begin
                    step(1);
                    n++;
                end
                check("init_en_found", LCD_EN, 1);
            end
            check("init_data", LCD_DATA, rom[k]);
            check("init_rs", LCD_RS, 0);
            check("init_ready_low", a_ready, 0);
            step(1);
            check("init_en_hold", LCD_EN, 1);
            step(1);
            check("init_en_fall", LCD_EN, 0);
            if (!full) break;
        end
        if (full) begin
            step(10);
            check("init_done_early", init_done, 0);
            step(1);
            check("init_done_rise", init_done, 1);
            check("init_busy_low", busy, 0);
        end
    endtask
`endif

    initial begin
        logic exp_b;
        rst = 1'b1;
        a_valid = 1'b0; a_rs = 1'b0; a_data = 8'h00;
        b_valid = 1'b0; b_rs = 1'b0; b_data = 8'h00;
        step(3);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        check("rst_en", LCD_EN, 0);
        check("rst_rs", LCD_RS, 0);
        check("rst_rw", LCD_RW, 0);
        check("rst_data", LCD_DATA, 8'h00);
        check("rst_init_done", init_done, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
`ifdef LCD_SCHED_INIT_SEQ_EN
        check("rst_busy", busy, 1);
`else
        check("rst_busy", busy, 0);
`endif
        a_valid = 1'b0;
        b_valid = 1'b0;
        step(1);
        rst = 1'b0;

`ifdef LCD_SCHED_INIT_SEQ_EN
        a_valid = 1'b1;
        #1;
        check("ready_during_pwrup", a_ready, 0);
        a_valid = 1'b0;
        check_init(1'b1);
        exp_b = 1'b0;
`else
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h55;
        #1;
        check("pre_edge_ready", a_ready, 0);
        check("pre_edge_init_done", init_done, 0);
        step(1);
        check("first_edge_init_done", init_done, 1);
        check("first_edge_ready", a_ready, 1);
        check("no_init_write", LCD_DATA, 8'h00);
        step(1);
        a_valid = 1'b0;
        check("noinit_data", LCD_DATA, 8'h55);
        check("noinit_rs", LCD_RS, 1);
        step(1);
        check("noinit_en", LCD_EN, 1);
        wait_idle(100);
        exp_b = 1'b1;
`endif

        // Both ports valid: grants alternate with back-to-back spacing.
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h41;
        b_valid = 1'b1; b_rs = 1'b1; b_data = 8'h42;
        #1;
        for (int g = 0; g < 4; g++) begin
            if (g > 0) begin
                step(13);
                check("rr_gap_a", a_ready, 0);
                check("rr_gap_b", b_ready, 0);
                step(1);
            end
            check("rr_ready_a", a_ready, !exp_b);
            check("rr_ready_b", b_ready, exp_b);
            step(1);
            check("rr_data", LCD_DATA, exp_b ? 8'h42 : 8'h41);
            exp_b = !exp_b;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_idle(100);

        // Port A data 0x41 with strobe shape and a B request withdrawn while busy.
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h41;
        #1;
        check("a41_ready", a_ready, 1);
        step(1);
        a_valid = 1'b0;
        check("a41_rs", LCD_RS, 1);
        check("a41_data", LCD_DATA, 8'h41);
        check("a41_setup_en", LCD_EN, 0);
        step(1);
        check("a41_en1", LCD_EN, 1);
        step(1);
        check("a41_en2", LCD_EN, 1);
        step(1);
        check("a41_hold_en", LCD_EN, 0);
        step(2);
        b_valid = 1'b1; b_rs = 1'b0; b_data = 8'h01;
        #1;
        check("busy_b_ready", b_ready, 0);
        step(1);
        b_valid = 1'b0;
        step(7);
        check("a41_busy_13", busy, 1);
        step(1);
        check("a41_idle_14", busy, 0);
        watch_no_en("dropped_valid_no_en", 5);
        check("dropped_valid_data", LCD_DATA, 8'h41);

        xfer(1'b1, 1'b0, 8'h01, 44);
        xfer(1'b1, 1'b0, 8'h80, 14);
        xfer(1'b0, 1'b0, 8'h03, 44);
        xfer(1'b0, 1'b0, 8'h04, 14);
        step(3);
        check("idle_hold_data", LCD_DATA, 8'h04);
        check("idle_hold_rs", LCD_RS, 0);

        // Reset mid-pulse: EN drops at once, request discarded.
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h33;
        #1;
        step(1);
        a_valid = 1'b0;
        step(1);
        check("pre_rst_en", LCD_EN, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_en", LCD_EN, 0);
        check("async_rst_data", LCD_DATA, 8'h00);
        check("async_rst_init_done", init_done, 0);
        step(1);
        rst = 1'b0;
`ifdef LCD_SCHED_INIT_SEQ_EN
        check_init(1'b0);
`else
        step(1);
        check("rerst_init_done", init_done, 1);
        check("rerst_busy", busy, 0);
        watch_no_en("rerst_no_en", 20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

- Owns the HD44780-class character LCD bus (LCD_RS/LCD_EN/LCD_RW/LCD_DATA).
- Runs the power-on init sequence, then shares the bus between two write requesters (port A, e.g. CRC digit writer; port B, e.g. status/test-result writer).
- Generates setup/enable/hold strobes and per-command execution waits from a single clock, so upstream logic never counts LCD delays itself.

## Interface
- CLK_MHZ, 50: clock frequency; documentation only, the counts below are derived from it.
- T_SU, 2: cycles RS/DATA are stable before EN rises.
- T_EN, 12: cycles EN is high.
- T_H, 2: cycles after EN falls, before the execution wait.
- T_SHORT, 2650: execution wait for normal command or data (53 us).
- T_LONG, 152000: execution wait for clear/home (3.04 ms).
- T_PWRUP, 750000: power-up delay before first init write (15 ms).
- T_INIT1, 205000: wait after init write 0 (4.1 ms).
- T_INIT2, 5000: wait after init write 1 (100 us).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  port A request.
- a_rs  in  1  port A: 0 = command, 1 = data.
- a_data  in  8  port A byte.
- a_ready  out  1  port A accept.
- b_valid, b_rs, b_data, b_ready: same as port A, for port B.
- init_done  out  1  init sequence finished.
- busy  out  1  high whenever state is not IDLE.
- LCD_RS  out  1  register select.
- LCD_EN  out  1  enable strobe.
- LCD_RW  out  1  constant 0 (write-only).
- LCD_DATA  out  8  bus data.

## Operation
- States: PWRUP, INIT, SETUP, PULSE, HOLD, WAIT, IDLE.
- Reset values: LCD_RS=0, LCD_EN=0, LCD_RW=0, LCD_DATA=8'h00, init_done=0, busy=1, a_ready=b_ready=0. State resets to PWRUP, init index to 0, last_grant to B.
- PWRUP: count T_PWRUP cycles, then go to INIT.
- INIT: load the init ROM entry (RS=0), then run SETUP→PULSE→HOLD→WAIT.
- Init ROM, byte with its wait:
  - 0x30, T_INIT1
  - 0x30, T_INIT2
  - 0x30, T_SHORT
  - 0x38, T_SHORT
  - 0x08, T_SHORT
  - 0x01, T_LONG
  - 0x06, T_SHORT
  - 0x0C, T_SHORT
- After the 8th WAIT: init_done=1 (sticky until reset), state IDLE.
- IDLE arbitration:
  - Only one valid: that port is granted.
  - Both valid: round-robin, the port not in last_grant wins.
  - a_ready = (state==IDLE) & grant_A; b_ready likewise; combinational from valid and state.
  - At most one ready is high at a time; ready is never high outside IDLE.
- Accept: valid&ready at an edge. Latch rs/data into LCD_RS/LCD_DATA, update last_grant, go to SETUP. Requesters hold rs/data stable while valid is high.
- Execution wait is T_LONG when rs==0 and data[7:2]==0 (0x01–0x03); otherwise T_SHORT.
- LCD_RS/LCD_DATA hold their last value through IDLE until the next accept.
- Valid dropped before ready: no transfer, no state change.

## Timing
- SETUP for T_SU cycles with EN=0, then PULSE for T_EN cycles with EN=1, then HOLD for T_H cycles with EN=0, then WAIT for T_exec cycles.
- IDLE is re-entered exactly T_SU+T_EN+T_H+T_exec cycles after the accept edge. Ready can reassert in that cycle, giving back-to-back throughput.
- Counter width must hold the largest parameter; counter reloads on every state entry.
- Reset asserted mid-transfer: outputs take reset values immediately (EN drops asynchronously), the latched request is discarded, and init restarts from PWRUP after release.
- Valid asserted during init: ignored (ready=0) until init_done=1.

## Configuration
- LCD_SCHED_INIT_SEQ_EN defined: PWRUP/INIT sequence compiled in as described.
- Not defined: PWRUP/INIT and the init ROM are removed. Reset state is IDLE and busy=0 after reset. init_done resets to 0 and goes to 1 on the first clock edge after rst deasserts. The host is then responsible for LCD init through port A/B.

## Test plan
Bench parameters: T_SU=1, T_EN=2, T_H=1, T_SHORT=10, T_LONG=40, T_PWRUP=20, T_INIT1=15, T_INIT2=12. Macro defined unless stated.
- Reset release, no requests → LCD_DATA sequence 30,30,30,38,08,01,06,0C with RS=0, exactly one EN pulse of 2 cycles each. First EN rise 21 cycles after release; init_done rises after 0x0C's wait.
- After init, A requests data 0x41 → a_ready high that cycle, LCD_RS=1, LCD_DATA=0x41, EN high 2 cycles. IDLE (ready possible) 14 cycles after accept.
- A and B both valid continuously → grants alternate A,B,A,B, starting with A.
- B sends command 0x01 → 44 cycles accept-to-IDLE. B sends 0x80 → 14 cycles.
- rst pulsed while LCD_EN=1 → EN=0 immediately, pending transfer lost, init sequence replays from the start.
- Macro undefined: init_done=1 one edge after reset release; an A request is accepted that cycle, with no init writes seen on LCD_DATA.
